dm_load_responder: RTL and testbench

- Data-memory responder for the pipeline's memory stage: the slave end of the store/load request interface the M stage drives.
- Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and commits byte-enabled writes.
- For loads, returns sign- or zero-extended read data to the W stage over a valid/ready response handshake.
- Exports `busy` so the hazard unit can freeze the pipeline while a request is outstanding.

---
 rtl/dm_load_responder_pkg.sv | 36 +++
 rtl/dm_load_responder_load_extender.sv | 26 ++
 rtl/dm_load_responder.sv | 168 ++++++++++++++++
 tb/tb_dm_load_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_load_responder_pkg.sv
// Shared types and constants for the data-memory load/store responder.
package dm_load_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LBU = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LHU = 3'b011;
  localparam logic [2:0] LT_LW  = 3'b100;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Alignment fault; unknown load codes are checked as full words.
  function automatic logic misaligned(input logic we, input logic [3:0] be,
                                      input logic [1:0] off, input logic [2:0] ltype);
    logic m;
    m = 1'b0;
    if (we) begin
      m = (be == BE_WORD) && (off != 2'b00);
    end else begin
      case (ltype)
        LT_LB, LT_LBU: m = 1'b0;
        LT_LH, LT_LHU: m = off[0];
        default:       m = (off != 2'b00);
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_load_responder_load_extender.sv
// Combinational lane select and sign/zero extension of a loaded word.
module dm_load_responder_load_extender
  import dm_load_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  ltype,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*off +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (ltype)
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {24'd0, byte_sel};
      LT_LH:   data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dm_load_responder.sv
// Data-memory responder: one request at a time, programmable wait states, byte-enabled
// stores and extended loads. Define DM_WRITE_LOG_EN to print every committed store.
module dm_load_responder
  import dm_load_responder_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ltype,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output state_t      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // once raised, rsp_valid and its payload hold until that edge.

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             accept, commit;

  logic        l_we;
  logic [3:0]  l_be;
  logic [31:0] l_addr, l_wdata, l_pc;
  logic [2:0]  l_ltype;

  logic [31:0] mem [DEPTH];

  logic              c_we, c_err, c_write;
  logic [3:0]        c_be;
  logic [31:0]       c_addr, c_wdata, c_pc, c_word, c_merged, c_ext;
  logic [2:0]        c_ltype;
  logic [ADDR_W-1:0] c_idx;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge, so it uses the live inputs.
  always_comb begin
    c_we    = (state == S_IDLE) ? req_we    : l_we;
    c_be    = (state == S_IDLE) ? req_be    : l_be;
    c_addr  = (state == S_IDLE) ? req_addr  : l_addr;
    c_wdata = (state == S_IDLE) ? req_wdata : l_wdata;
    c_ltype = (state == S_IDLE) ? req_ltype : l_ltype;
    c_pc    = (state == S_IDLE) ? req_pc    : l_pc;
    c_idx   = c_addr[ADDR_W+1:2];
    c_err   = misaligned(c_we, c_be, c_addr[1:0], c_ltype) | (|(c_addr >> (ADDR_W + 2)));
    c_write = commit && c_we && !c_err && (c_be != BE_NONE);
    c_word  = mem[c_idx];
    c_merged = c_word;
    for (int b = 0; b < 4; b++) begin
      if (c_be[b]) c_merged[8*b +: 8] = c_wdata[8*b +: 8];
    end
  end

  dm_load_responder_load_extender u_load_extender (
    .word  (c_word),
    .off   (c_addr[1:0]),
    .ltype (c_ltype),
    .data  (c_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_be      <= '0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_ltype   <= '0;
      l_pc      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        l_we    <= req_we;
        l_be    <= req_be;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_ltype <= req_ltype;
        l_pc    <= req_pc;
      end
      if (commit) begin
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (c_we || c_err) ? 32'd0 : c_ext;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (c_write) begin
      mem[c_idx] <= c_merged;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset && c_write)
      $display("@%08h: *%08h <= %08h", c_pc, {c_addr[31:2], 2'b00}, c_merged);
  end
`else
  logic pc_unused;
  assign pc_unused = ^c_pc;
`endif

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dm_load_responder.sv
// Bench for dm_load_responder: directed vector table, multi-cycle corner sequences,
// and random traffic scored against a word-array model of the memory.
module tb_dm_load_responder;
  import dm_load_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid_a, req_valid_b, req_we, rsp_ready;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [2:0]  req_ltype;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  state_t      dbg_a, dbg_b;

  dm_load_responder dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ltype(req_ltype), .req_pc(req_pc), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  dm_load_responder #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ltype(req_ltype), .req_pc(req_pc), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem [int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  function automatic logic cur_rr(input bit sel);
    return sel ? req_ready_b : req_ready_a;
  endfunction
  function automatic logic cur_rv(input bit sel);
    return sel ? rsp_valid_b : rsp_valid_a;
  endfunction
  function automatic logic cur_er(input bit sel);
    return sel ? rsp_err_b : rsp_err_a;
  endfunction
  function automatic logic [31:0] cur_rd(input bit sel);
    return sel ? rsp_rdata_b : rsp_rdata_a;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Reference model for the 4096-word instance: returns {err, rdata}.
  function automatic logic [32:0] model_access(input logic we, input logic [3:0] be,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] lt);
    int unsigned off, size, idx;
    int x;
    logic [31:0] w;
    off  = addr % 4;
    idx  = addr / 4;
    size = (lt <= 3'd1) ? 1 : (lt <= 3'd3) ? 2 : 4;
    if (addr >= 32'd16384) return {1'b1, 32'd0};
    if (we && be == 4'hF && off != 0) return {1'b1, 32'd0};
    if (!we && (off % size) != 0) return {1'b1, 32'd0};
    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[idx] = w;
      return {1'b0, 32'd0};
    end
    if (size == 1) begin
      x = int'((w >> (8 * off)) % 256);
      if (lt == 3'd0 && x > 127) x = x - 256;
    end else if (size == 2) begin
      x = int'((w >> (8 * off)) % 65536);
      if (lt == 3'd2 && x > 32767) x = x - 65536;
    end else begin
      x = int'(w);
    end
    return {1'b0, 32'(x)};
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input bit sel, input logic we, input logic [3:0] be,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] lt, input int hold,
      output logic [31:0] rd, output logic err, output int lat, output bit ok);
    int guard;
    ok = 1'b0; rd = '0; err = 1'b0; lat = 0;
    @(negedge clk);
    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_ltype = lt;
    req_pc = 32'h0000_1000 + 32'($urandom_range(0, 255)) * 4;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    guard = 0;
    while (!cur_rr(sel) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      fail_now("accept");
      req_valid_a = 1'b0; req_valid_b = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    check("ready_drop", {31'd0, cur_rr(sel)}, 32'd0);
    @(negedge clk);
    lat = 1;
    while (!cur_rv(sel) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!cur_rv(sel)) begin
      fail_now("rsp_valid");
      return;
    end
    rd = cur_rd(sel);
    err = cur_er(sel);
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, cur_rv(sel)}, 32'd1);
      check("hold_rdata", cur_rd(sel), rd);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("valid_clear", {31'd0, cur_rv(sel)}, 32'd0);
    check("busy_clear", {31'd0, cur_busy(sel)}, 32'd0);
    check("rdata_clear", cur_rd(sel), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  lt;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic err;
    int lat;
    bit ok;
    logic [32:0] exp;

    reset = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0; req_we = 1'b0; req_be = '0;
    req_addr = '0; req_wdata = '0; req_ltype = '0; req_pc = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);

    // directed vectors (WAIT_CYCLES = 2 instance)
    vecs.push_back('{1'b1, 4'hF, 32'h10, 32'h1234_5678, LT_LW,  0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h10, 32'h0,         LT_LW,  0, 1'b0, 32'h1234_5678});
    vecs.push_back('{1'b1, 4'h4, 32'h12, 32'h00AB_0000, LT_LW,  0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h10, 32'h0,         LT_LW,  1, 1'b0, 32'h12AB_5678});
    vecs.push_back('{1'b0, 4'h0, 32'h12, 32'h0,         LT_LB,  0, 1'b0, 32'hFFFF_FFAB});
    vecs.push_back('{1'b0, 4'h0, 32'h12, 32'h0,         LT_LBU, 0, 1'b0, 32'h0000_00AB});
    vecs.push_back('{1'b1, 4'hF, 32'h20, 32'h8001_FFFF, LT_LW,  0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h22, 32'h0,         LT_LH,  5, 1'b0, 32'hFFFF_8001});
    vecs.push_back('{1'b0, 4'h0, 32'h22, 32'h0,         LT_LHU, 0, 1'b0, 32'h0000_8001});
    vecs.push_back('{1'b0, 4'h0, 32'h21, 32'h0,         LT_LH,  0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h22, 32'h0,         LT_LW,  0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h21, 32'h0,         LT_LW,  0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h20, 32'h0,         LT_LW,  0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h20, 32'h0,         LT_LW,  0, 1'b0, 32'h8001_FFFF});
    vecs.push_back('{1'b0, 4'h0, 32'h20, 32'h0,         LT_LB,  0, 1'b0, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 4'h0, 32'h23, 32'h0,         LT_LBU, 0, 1'b0, 32'h0000_0080});
    vecs.push_back('{1'b0, 4'h0, 32'h4000, 32'h0,       LT_LW,  0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h10, 32'h0,         3'b111, 0, 1'b0, 32'h12AB_5678});
    vecs.push_back('{1'b1, 4'h3, 32'h22, 32'h0000_BEEF, LT_LW,  0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h20, 32'h0,         LT_LW,  0, 1'b0, 32'h8001_BEEF});
    vecs.push_back('{1'b0, 4'h0, 32'h21, 32'h0,         LT_LHU, 0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h13, 32'h0,         LT_LB,  0, 1'b0, 32'h0000_0012});

    foreach (vecs[i]) begin
      do_req(1'b0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].lt,
             vecs[i].hold, rd, err, lat, ok);
      if (ok) begin
        check("vec_latency", 32'(lat), 32'd3);
        check("vec_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
        check("vec_rdata", rd, vecs[i].exp_rd);
      end
    end

    // rsp_ready while idle has no effect
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rdy_busy", {31'd0, busy_a}, 32'd0);
    check("idle_rdy_valid", {31'd0, rsp_valid_a}, 32'd0);
    rsp_ready = 1'b0;

    // reset during WAIT drops the store and clears memory
    @(negedge clk);
    req_we = 1'b1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    req_ltype = LT_LW; req_valid_a = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a = 1'b0;
    check("wait_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_valid", {31'd0, rsp_valid_a}, 32'd0);
    check("midrst_rdata", rsp_rdata_a, 32'd0);
    check("midrst_err", {31'd0, rsp_err_a}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_mem.delete();
    do_req(1'b0, 1'b0, 4'h0, 32'h30, 32'h0, LT_LW, 0, rd, err, lat, ok);
    if (ok) check("post_rst_lw30", rd, 32'd0);
    do_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, LT_LW, 0, rd, err, lat, ok);
    if (ok) check("post_rst_lw10", rd, 32'd0);

    // zero-wait-state instance
    do_req(1'b1, 1'b1, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF, LT_LW, 0, rd, err, lat, ok);
    if (ok) begin
      check("w0_latency", 32'(lat), 32'd1);
      check("w0_oor_err", {31'd0, err}, 32'd1);
      check("w0_oor_rdata", rd, 32'd0);
    end
    do_req(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, LT_LW, 0, rd, err, lat, ok);
    if (ok) check("w0_no_write", rd, 32'd0);
    do_req(1'b1, 1'b1, 4'hF, 32'h4, 32'h55AA_33CC, LT_LW, 1, rd, err, lat, ok);
    if (ok) check("w0_sw_err", {31'd0, err}, 32'd0);
    do_req(1'b1, 1'b0, 4'h0, 32'h6, 32'h0, LT_LH, 0, rd, err, lat, ok);
    if (ok) begin
      check("w0_latency2", 32'(lat), 32'd1);
      check("w0_lh", rd, 32'h0000_55AA);
    end

    // random traffic against the model
    for (int n = 0; n < 200; n++) begin
      logic        r_we;
      logic [3:0]  r_be;
      logic [31:0] r_addr, r_wdata;
      logic [2:0]  r_lt;
      r_we    = 1'($urandom_range(0, 1));
      r_be    = 4'($urandom_range(0, 15));
      r_addr  = ($urandom_range(0, 15) == 0) ? 32'h0000_4000 + 32'($urandom_range(0, 255))
                                             : 32'($urandom_range(0, 63));
      r_wdata = $urandom;
      r_lt    = 3'($urandom_range(0, 7));
      exp_q.push_back(model_access(r_we, r_be, r_addr, r_wdata, r_lt));
      do_req(1'b0, r_we, r_be, r_addr, r_wdata, r_lt, $urandom_range(0, 2), rd, err, lat, ok);
      exp = exp_q.pop_front();
      if (ok) begin
        check("rand_err", {31'd0, err}, {31'd0, exp[32]});
        check("rand_rdata", rd, exp[31:0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
